// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding,
// vector geometry and an 8-bit population count helper.
package sweeper_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;

    function automatic logic [3:0] popcount8(input logic [NUM_VECTORS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_VECTORS; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the sweeper (slave side) and its environment
// (master side: requests sweeps and closes the loop through the circuit under test).
interface truth_table_sweeper_if
    import sweeper_pkg::*;
();

    logic                   start;
    logic                   z;
    logic                   x2;
    logic                   x1;
    logic                   x0;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] result;
    logic [3:0]             ones;

    modport slave (
        input  start, z,
        output x2, x1, x0, busy, done, result, ones
    );

    modport master (
        output start, z,
        input  x2, x1, x0, busy, done, result, ones
    );

endinterface

// File: rtl/truth_table_sweeper_dwell_counter.sv
// Per-vector dwell timer: counts enabled cycles and flags the last one so the
// sweeper knows when to sample z and advance.
module sweep_dwell_counter #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int unsigned     CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_count;

    assign last = enable && (r_count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight input vectors of a 3-input circuit in ascending order, samples
// z at the end of each dwell period and publishes the truth table with its popcount.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.slave  bus
);

    state_t                 r_state;
    logic [VEC_W-1:0]       r_index;
    logic [NUM_VECTORS-1:0] r_table;
    logic [NUM_VECTORS-1:0] r_result;
    logic [3:0]             r_ones;
    logic                   r_done;

    logic                   w_run;
    logic                   w_begin;
    logic                   w_last;
    logic                   w_final;
    logic [VEC_W-1:0]       w_vec;
    logic [NUM_VECTORS-1:0] w_table_next;

    assign w_run   = (r_state == RUN);
    assign w_begin = (r_state == IDLE) && bus.start;

    sweep_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_begin),
        .enable (w_run),
        .last   (w_last)
    );

    // Table including the bit being sampled this cycle, so the final sample
    // reaches result/ones on the same edge that ends the sweep.
    always_comb begin
        w_table_next          = r_table;
        w_table_next[r_index] = bus.z;
    end

    assign w_final = w_run && w_last && (r_index == VEC_W'(NUM_VECTORS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_index  <= '0;
            r_table  <= '0;
            r_result <= '0;
            r_ones   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_index <= '0;
                        r_table <= '0;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_table <= w_table_next;
                        if (w_final) begin
                            r_state  <= IDLE;
                            r_index  <= '0;
                            r_result <= w_table_next;
                            r_ones   <= popcount8(w_table_next);
                            r_done   <= 1'b1;
                        end else begin
                            r_index <= r_index + VEC_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_vec = w_run ? r_index : '0;

    assign bus.x2     = w_vec[2];
    assign bus.x1     = w_vec[1];
    assign bus.x0     = w_vec[0];
    assign bus.busy   = w_run;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.ones   = r_ones;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance at DWELL=4 with a selectable
// circuit model, one at DWELL=1 driven by z=x0.
module tb_truth_table_sweeper;

    localparam int M_PAR   = 0;
    localparam int M_AND   = 1;
    localparam int M_ONE   = 2;

    logic clk;
    logic rst;
    int   mode;
    int   checks;
    int   errors;

    truth_table_sweeper_if ifa ();
    truth_table_sweeper_if ifb ();

    truth_table_sweeper #(.DWELL(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    truth_table_sweeper #(.DWELL(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circuit-under-test models
    always_comb begin
        case (mode)
            M_PAR:   ifa.z = ifa.x2 ^ ifa.x1 ^ ifa.x0;
            M_AND:   ifa.z = ifa.x2 & ifa.x1;
            M_ONE:   ifa.z = 1'b1;
            default: ifa.z = 1'b0;
        endcase
    end

    always_comb ifb.z = ifb.x0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Starts a DWELL=4 sweep in the current cycle (cycle 0) and checks it through done.
    task automatic sweep_a(input logic [7:0] eres, input logic [3:0] eones, input int poke_at);
        ifa.start = 1'b1;
        chk("a_c0_busy", 32'(ifa.busy), 32'd0);
        for (int c = 1; c <= 32; c++) begin
            step();
            if (c == 1)           ifa.start = 1'b0;
            if (c == poke_at)     ifa.start = 1'b1;
            if (c == poke_at + 1) ifa.start = 1'b0;
            chk("a_busy", 32'(ifa.busy), 32'd1);
            chk("a_done_early", 32'(ifa.done), 32'd0);
            chk("a_vec", 32'({ifa.x2, ifa.x1, ifa.x0}), 32'((c - 1) / 4));
        end
        step();
        chk("a_done", 32'(ifa.done), 32'd1);
        chk("a_busy_end", 32'(ifa.busy), 32'd0);
        chk("a_vec_end", 32'({ifa.x2, ifa.x1, ifa.x0}), 32'd0);
        chk("a_result", 32'(ifa.result), 32'(eres));
        chk("a_ones", 32'(ifa.ones), 32'(eones));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mode      = M_PAR;
        rst       = 1'b1;
        ifa.start = 1'b1;
        ifb.start = 1'b1;

        // Reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_vec", 32'({ifa.x2, ifa.x1, ifa.x0}), 32'd0);
            chk("rst_busy", 32'(ifa.busy), 32'd0);
            chk("rst_done", 32'(ifa.done), 32'd0);
            chk("rst_result", 32'(ifa.result), 32'd0);
            chk("rst_ones", 32'(ifa.ones), 32'd0);
            chk("rst_b_busy", 32'(ifb.busy), 32'd0);
        end
        rst       = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        step();
        chk("idle_busy", 32'(ifa.busy), 32'd0);

        // Parity model: 0,1,1,0,1,0,0,1 -> 8'h96
        mode = M_PAR;
        sweep_a(8'h96, 4'd4, -1);
        step();
        chk("done_pulse_single", 32'(ifa.done), 32'd0);
        chk("result_hold", 32'(ifa.result), 32'h96);

        // AND of x2,x1 with a start poke at cycle 10 -> 8'hC0
        mode = M_AND;
        sweep_a(8'hC0, 4'd2, 10);
        step();
        chk("and_idle", 32'(ifa.busy), 32'd0);

        // Fresh parity result, then reset while vector 5 is driven
        mode = M_PAR;
        sweep_a(8'h96, 4'd4, -1);
        ifa.start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            step();
            if (c == 1) ifa.start = 1'b0;
        end
        chk("mid_vec5", 32'({ifa.x2, ifa.x1, ifa.x0}), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_vec", 32'({ifa.x2, ifa.x1, ifa.x0}), 32'd0);
        chk("mid_rst_busy", 32'(ifa.busy), 32'd0);
        chk("mid_rst_result", 32'(ifa.result), 32'd0);
        chk("mid_rst_ones", 32'(ifa.ones), 32'd0);
        for (int c = 0; c < 40; c++) begin
            step();
            chk("mid_no_done", 32'(ifa.done), 32'd0);
            chk("mid_no_busy", 32'(ifa.busy), 32'd0);
        end

        // Back-to-back sweeps with start held high
        mode      = M_PAR;
        ifa.start = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            step();
            chk("b2b1_busy", 32'(ifa.busy), 32'd1);
        end
        step();
        chk("b2b1_done", 32'(ifa.done), 32'd1);
        chk("b2b1_result", 32'(ifa.result), 32'h96);
        chk("b2b1_busy_gap", 32'(ifa.busy), 32'd0);
        mode = M_ONE;
        for (int c = 34; c <= 65; c++) begin
            step();
            chk("b2b2_busy", 32'(ifa.busy), 32'd1);
            chk("b2b2_hold", 32'(ifa.result), 32'h96);
            chk("b2b2_vec", 32'({ifa.x2, ifa.x1, ifa.x0}), 32'((c - 34) / 4));
        end
        step();
        ifa.start = 1'b0;
        chk("b2b2_done", 32'(ifa.done), 32'd1);
        chk("b2b2_result", 32'(ifa.result), 32'hFF);
        chk("b2b2_ones", 32'(ifa.ones), 32'd8);
        step();
        chk("b2b_stop", 32'(ifa.busy), 32'd0);

        // Minimum dwell: z = x0 -> 8'hAA
        ifb.start = 1'b1;
        chk("b_c0_busy", 32'(ifb.busy), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) ifb.start = 1'b0;
            chk("b_vec", 32'({ifb.x2, ifb.x1, ifb.x0}), 32'(c - 1));
            chk("b_busy", 32'(ifb.busy), 32'd1);
            chk("b_done_early", 32'(ifb.done), 32'd0);
        end
        step();
        chk("b_done", 32'(ifb.done), 32'd1);
        chk("b_busy_end", 32'(ifb.busy), 32'd0);
        chk("b_result", 32'(ifb.result), 32'hAA);
        chk("b_ones", 32'(ifb.ones), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Upstream stimulus/capture stage for the 3-input, 1-output `TextbookCircuit`. On `start` it drives all eight input combinations `x2 x1 x0` = 000…111 in ascending order. It holds each vector for a programmable dwell period and samples `z` on the last dwell cycle. It then publishes the complete 8-entry truth table and its population count, turning the manual testbench sweep into a synthesizable, on-board self-check.

## Interface
Parameters:
- `DWELL`, default 4: cycles each vector is held; legal range 1..255.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a sweep; accepted only in IDLE.
- `z` input 1: response from the circuit under test; treated as combinational from `x2..x0`.
- `x2`, `x1`, `x0` output 1 each: stimulus vector to the circuit under test; `x2` is the MSB.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: single-cycle pulse when a sweep completes.
- `result` output 8: last completed truth table; bit i holds z for vector i.
- `ones` output 4: number of 1s in `result` (0..8).

## Operation
- The FSM has two states, IDLE and RUN.
- IDLE → RUN when `start`=1. On that transition: vector index ← 0, dwell count ← 0, working table ← 0.
- In RUN, `{x2,x1,x0}` equals the vector index.
- The dwell count increments each cycle. When it equals DWELL-1, `z` is written to working-table bit [index], the dwell count clears, and the index increments.
- When index 7 is sampled, the FSM returns to IDLE. At that same edge, `result` ← final working table (including bit 7) and `ones` ← popcount of it.
- `start` is ignored while in RUN. There is no abort input; only `rst` aborts a sweep.
- In IDLE, `{x2,x1,x0}` = 000.
- `result` and `ones` hold their value until the next completed sweep. An aborted sweep never updates them.
- Index and dwell count never wrap inside a sweep. The index is 3 bits, and the end is detected on index==7 at the sample cycle.

## Timing
- Reset values: state IDLE, `x2..x0`=0, `busy`=0, `done`=0, `result`=0, `ones`=0; working table, index and counter all 0.
- Cycle 0 is the cycle in which `start`=1 is sampled in IDLE.
- Vector i is driven during cycles 1+i·DWELL … (i+1)·DWELL. `z` is sampled at the rising edge that ends cycle (i+1)·DWELL.
- `busy`=1 during cycles 1…8·DWELL.
- In cycle 8·DWELL+1: `done`=1, `busy`=0, `result`/`ones` valid, vector back to 000.
- Total latency from start to done is 8·DWELL+1 cycles.
- `start` is sampled in the `done` cycle (state is IDLE). With `start` held high, the next sweep's cycle 0 is the `done` cycle, and back-to-back sweeps have no gap.
- `rst` asserted in any cycle, including mid-sweep or coincident with `start`: all registers take reset values at that edge, and `rst` has priority over `start`.
- DWELL=1: each vector is driven and sampled in the same cycle. This relies on `z` settling within one clock period.

## Structure
- Package `sweeper_pkg`:
  - state enum {IDLE, RUN}
  - `NUM_VECTORS`=8
  - `VEC_W`=3
  - popcount function for 8 bits
- Sub-module `sweep_dwell_counter`:
  - parameterised on DWELL
  - inputs: `clear`, `enable`
  - output: `last` pulse when count==DWELL-1
  - width is `$clog2(DWELL)` with a minimum of 1
- Top level holds the FSM, index register, working table, result register and popcount register.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `start`=1 → all outputs 0, `busy`=0, no `done`.
- **Parity model, DWELL=4:** drive `z`=x2^x1^x0 and pulse `start` → `busy` in cycles 1..32, `done` in cycle 33, `result`=8'h96, `ones`=4.
- **Start while busy, AND model:** drive `z`=x2&x1 and pulse `start` again at cycle 10 → ignored, `done` still at cycle 33, `result`=8'hC0, `ones`=2.
- **Mid-sweep reset:** assert `rst` while vector 5 is driven after a previous result of 8'h96 → next cycle all outputs 0, `result`=0, no `done` pulse.
- **Back-to-back sweeps:** hold `start` high with the parity model then switch `z` to constant 1 → the second sweep's cycle 0 is the first `done` cycle, `result` stays 8'h96 until the second `done` 33 cycles later, then becomes 8'hFF with `ones`=8.
- **Minimum dwell:** DWELL=1 with `z`=x0 → vector i is driven in cycle i+1, `done` in cycle 9, `result`=8'hAA.
